// File: rtl/fft_pkg.sv
// Shared defaults and reader state encoding for the audio-to-FFT frame buffer.
package fft_pkg;

    localparam int FRAME_LEN_DEF = 256;
    localparam int SAMPLE_W_DEF  = 16;
    localparam int SAMPLE_IN_W   = 32;
    localparam int FRAME_CNT_W   = 16;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_PRESENT
    } rd_state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module frame_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // NOTE: neither the array nor the read register is reset, so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer: collects software-written samples into two banks and
// streams each completed frame to the FFT over valid/ready with an end-of-frame marker.
module audio_frame_buffer
    import fft_pkg::*;
#(
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    parameter  int SAMPLE_W  = SAMPLE_W_DEF,
    localparam int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_valid,
    input  logic [SAMPLE_IN_W-1:0] sample_data,
    output logic [SAMPLE_W-1:0]    out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    // Writer state
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]        full_q, full_d, full_set, full_clr;
    logic              overflow_q, overflow_d;

    // Reader state
    rd_state_e             state_q, state_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]     rd_idx_q, rd_idx_d;
    logic [SAMPLE_W-1:0]   out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    // RAM interface
    logic                ram_we;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_rd_idx;
    logic [SAMPLE_W-1:0] ram_rd_data;

    // Only the low SAMPLE_W bits of the peripheral word carry audio.
    logic unused_sample_hi;
    assign unused_sample_hi = ^sample_data[SAMPLE_IN_W-1:SAMPLE_W];

    frame_ram #(
        .DATA_W (SAMPLE_W),
        .ADDR_W (ADDR_W + 1)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr ({wr_bank_q, wr_idx_q}),
        .wr_data (sample_data[SAMPLE_W-1:0]),
        .rd_en   (ram_re),
        .rd_addr ({rd_bank_q, ram_rd_idx}),
        .rd_data (ram_rd_data)
    );

    // NOTE: blocking (=) in always_comb, every output given a default first, so no latch is inferred.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_idx_d   = wr_idx_q;
        full_set   = '0;
        overflow_d = overflow_q;
        ram_we     = 1'b0;

        // Clear first so a drop on the same cycle wins.
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end

        if (sample_valid) begin
            if (full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end else begin
                ram_we = 1'b1;
                if (wr_idx_q == LAST_IDX) begin
                    full_set[wr_bank_q] = 1'b1;
                    wr_bank_d           = ~wr_bank_q;
                    wr_idx_d            = '0;
                end else begin
                    wr_idx_d = wr_idx_q + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rd_bank_d     = rd_bank_q;
        rd_idx_d      = rd_idx_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        frame_count_d = frame_count_q;
        full_clr      = '0;
        ram_re        = 1'b0;
        ram_rd_idx    = rd_idx_q;

        unique case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    ram_re  = 1'b1;
                    state_d = RD_FETCH;
                end
            end
            RD_FETCH: begin
                out_data_d  = ram_rd_data;
                out_valid_d = 1'b1;
                out_last_d  = (rd_idx_q == LAST_IDX);
                state_d     = RD_PRESENT;
            end
            RD_PRESENT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (rd_idx_q == LAST_IDX) begin
                        full_clr[rd_bank_q] = 1'b1;
                        rd_bank_d           = ~rd_bank_q;
                        rd_idx_d            = '0;
                        frame_count_d       = frame_count_q + FRAME_CNT_W'(1);
                        state_d             = RD_IDLE;
                    end else begin
                        rd_idx_d   = rd_idx_q + ADDR_W'(1);
                        ram_rd_idx = rd_idx_q + ADDR_W'(1);
                        ram_re     = 1'b1;
                        state_d    = RD_FETCH;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Writer and reader always touch different banks, so set and clear never collide.
    assign full_d = (full_q | full_set) & ~full_clr;

    // NOTE: non-blocking (<=) for every flop so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            full_q        <= '0;
            overflow_q    <= 1'b0;
            state_q       <= RD_IDLE;
            rd_bank_q     <= 1'b0;
            rd_idx_q      <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            wr_idx_q      <= wr_idx_d;
            full_q        <= full_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
            rd_bank_q     <= rd_bank_d;
            rd_idx_q      <= rd_idx_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/audio_frame_buffer.md
Name: audio_frame_buffer

Overview:
Downstream of the Avalon audio sample register. Collects each 32-bit sample written by software into one of two FRAME_LEN-deep ping-pong banks. Streams each completed frame, in order, to the FFT input over a valid/ready interface with an end-of-frame marker. Flags overflow when software writes while both banks are still full.

Parameters:
FRAME_LEN, 256, samples per FFT frame; power of two, minimum 4
SAMPLE_W, 16, sample width; sample = sample_data[SAMPLE_W-1:0]
ADDR_W, $clog2(FRAME_LEN), index width (derived; do not override)

Ports:
clk  in  1  system clock (single clock domain)
reset_n  in  1  asynchronous, active-low reset
sample_valid  in  1  one-cycle strobe: asserted on the cycle the peripheral register takes a chipselect&&write
sample_data  in  32  sample word, i.e. the peripheral's audio_content value
out_data  out  SAMPLE_W  sample presented to FFT
out_valid  out  1  out_data valid
out_ready  in  1  FFT accepts out_data
out_last  out  1  high with the final sample (index FRAME_LEN-1) of a frame
frame_count  out  16  count of fully delivered frames; wraps
overflow  out  1  sticky: a sample was dropped
overflow_clr  in  1  clears overflow

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, out_last=0, out_data=0, frame_count=0, overflow=0. Also wr_bank=0, wr_idx=0, rd_bank=0, rd_idx=0, full[1:0]=0, FSM=IDLE. Bank contents are not reset. Any partial frame in flight is discarded.
- Writer, on a sample_valid cycle:
  - If full[wr_bank]=1: drop the sample and set overflow. wr_idx is unchanged.
  - Otherwise: write mem[wr_bank][wr_idx] and increment wr_idx.
  - If wr_idx was FRAME_LEN-1: set full[wr_bank], toggle wr_bank, set wr_idx=0.
- overflow_clr: clears overflow. If a drop happens on the same cycle, the set wins.
- Reader FSM (memory read is synchronous, 1-cycle latency):
  - IDLE: if full[rd_bank], issue read of mem[rd_bank][rd_idx] and go to FETCH.
  - FETCH: register the read data into out_data. Set out_valid=1 and out_last=(rd_idx==FRAME_LEN-1). Go to PRESENT.
  - PRESENT: hold out_data, out_valid and out_last stable while out_ready=0.
  - PRESENT on handshake (out_valid&&out_ready): drop out_valid and out_last.
    - If not last: increment rd_idx, issue the next read, go to FETCH.
    - If last: clear full[rd_bank], toggle rd_bank, set rd_idx=0, increment frame_count, go to IDLE.
- Throughput: at most one sample per 2 clocks. A frame can begin streaming no earlier than the cycle after the full flag sets (IDLE sees full, then FETCH). First out_valid comes 2 cycles after the full flag is visible.
- Banks alternate strictly, so frames leave in arrival order. out_valid never depends combinationally on out_ready.
- Simultaneous events:
  - Writer setting full[x] and reader clearing full[y] in the same cycle (x≠y): both take effect.
  - Writer write to bank x while reader reads bank y: no conflict, since x never equals y while full[y]=1.
  - A write that completes bank x on the same cycle the reader frees bank x is impossible (the writer stalls on full).
  - A sample arriving on the same cycle the reader clears full[wr_bank] is dropped. The full check uses the registered value.
- frame_count wraps from 0xFFFF to 0x0000.

Decomposition:
- Shared package fft_pkg: FRAME_LEN and SAMPLE_W defaults, and the reader state enum (IDLE, FETCH, PRESENT).
- One sub-module, frame_ram: simple dual-port, 2*FRAME_LEN x SAMPLE_W, one write port and one synchronous read port, address {bank, idx}. Written so it infers block RAM.

Test Plan:
- Fill frame, FRAME_LEN=4, out_ready=1: writes 0x11,0x22,0x33,0x44 -> out_data sequence 0x11,0x22,0x33,0x44; out_last only on 0x44; frame_count=1; overflow=0.
- Back-to-back frames: 8 writes 1..8 with out_ready=0 until all are written, then out_ready=1 -> out_data 1..8 in order; out_last on 4 and 8; frame_count=2.
- Overflow: out_ready=0, 9 writes 1..9 -> overflow=1; sample 9 dropped. Release out_ready -> exactly 1..8 delivered. Pulse overflow_clr -> overflow=0.
- Backpressure: toggle out_ready randomly -> out_data, out_valid and out_last hold while out_ready=0; no duplicated or skipped sample.
- Width: sample_data=0xDEADBEEF, SAMPLE_W=16 -> out_data=0xBEEF.
- Mid-frame reset: assert reset_n=0 after 2 writes or mid-stream -> outputs 0 immediately (asynchronous). After release, a fresh 4-write frame streams correctly and frame_count restarts from 0.
